// File: rtl/next_pc_sched.sv
// Fetch-address scheduler: boots from RESET_PC and advances PC_F by 4 on each advance.
// Decode redirects are applied at once, or held in a one-entry buffer while imem stalls.
module next_pc_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_D,
  input  logic             imem_ready,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_sel,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      NPC_J,
  input  logic [31:0]      NPC_JR,
  output logic [31:0]      PC_F,
  output logic             fetch_req,
  output logic             pend_valid,
  output logic             addr_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  // state | meaning
  // BOOT  | first cycle after reset, no fetch, redirects ignored
  // FETCH | fetch request issued, imem was ready last cycle
  // WAIT  | fetch request held while imem is not ready
  typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

  state_t      state;
  logic [31:0] pend_tgt;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        active;
  logic        advance;
  logic        take_redir;

  always_comb begin
    redir_raw = branch_target;
    unique case (redirect_sel)
      2'b01:   redir_raw = NPC_J;
      2'b10:   redir_raw = NPC_JR;
      default: redir_raw = branch_target;
    endcase
  end

  assign redir_tgt  = {redir_raw[31:2], 2'b00};
  assign active     = (state == FETCH) || (state == WAIT);
  assign advance    = active && imem_ready && !stall_D;
  // A stalled decode re-presents its redirect, so only unstalled ones are taken.
  assign take_redir = active && redirect_valid && !stall_D;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      PC_F         <= RESET_PC;
      fetch_req    <= 1'b0;
      pend_valid   <= 1'b0;
      pend_tgt     <= RESET_PC;
      addr_err     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state     <= FETCH;
          fetch_req <= 1'b1;
        end
        FETCH: if (!imem_ready) state <= WAIT;
        WAIT:  if (imem_ready) state <= FETCH;
        default: begin
          state     <= BOOT;
          fetch_req <= 1'b0;
        end
      endcase

      if (take_redir && (redir_raw[1:0] != 2'b00))
        addr_err <= 1'b1;

      if (advance) begin
        pend_valid <= 1'b0;
        if (take_redir) begin
          PC_F <= redir_tgt;
          if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
        end else if (pend_valid) begin
          PC_F <= pend_tgt;
          if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
        end else begin
          PC_F <= PC_F + 32'd4;
        end
      end else if (take_redir) begin
        // Latest redirect wins while the buffer waits for imem.
        pend_tgt   <= redir_tgt;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_sched.sv
// Directed bench for next_pc_sched: boot sequence, redirects, buffering, stall, alignment, wrap, reset.
module tb_next_pc_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_D, imem_ready, redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] branch_target, NPC_J, NPC_JR;
  logic [31:0] PC_F, pc_s;
  logic        fetch_req, pend_valid, addr_err;
  logic        freq_s, pend_s, err_s;
  logic [15:0] redirect_cnt;
  logic [1:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  next_pc_sched dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .imem_ready(imem_ready),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .branch_target(branch_target), .NPC_J(NPC_J), .NPC_JR(NPC_JR),
    .PC_F(PC_F), .fetch_req(fetch_req), .pend_valid(pend_valid),
    .addr_err(addr_err), .redirect_cnt(redirect_cnt)
  );

  // Narrow-counter copy driven identically, used to see saturation quickly.
  next_pc_sched #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall_D(stall_D), .imem_ready(imem_ready),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .branch_target(branch_target), .NPC_J(NPC_J), .NPC_JR(NPC_JR),
    .PC_F(pc_s), .fetch_req(freq_s), .pend_valid(pend_s),
    .addr_err(err_s), .redirect_cnt(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] j,
                       input logic [31:0] jr);
    redirect_valid = 1'b1;
    redirect_sel   = sel;
    branch_target  = bt;
    NPC_J          = j;
    NPC_JR         = jr;
  endtask

  initial begin
    reset = 1'b0; stall_D = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
    redirect_sel = 2'b00; branch_target = '0; NPC_J = '0; NPC_JR = '0;
    #12;
    check("rst_pc", PC_F, 32'h3000);
    check("rst_freq", {31'b0, fetch_req}, 32'd0);
    check("rst_pend", {31'b0, pend_valid}, 32'd0);
    check("rst_err", {31'b0, addr_err}, 32'd0);
    check("rst_cnt", {16'b0, redirect_cnt}, 32'd0);

    step(); reset = 1'b1;
    step();
    check("boot_pc", PC_F, 32'h3000);
    check("boot_freq", {31'b0, fetch_req}, 32'd1);
    step(); check("seq_3004", PC_F, 32'h3004);
    step(); check("seq_3008", PC_F, 32'h3008);

    redir(2'b01, 32'h0, 32'h3100, 32'h0);
    step();
    check("j_pc", PC_F, 32'h3100);
    check("j_cnt", {16'b0, redirect_cnt}, 32'd1);
    check("j_err", {31'b0, addr_err}, 32'd0);
    redirect_valid = 1'b0;
    step(); check("seq_3104", PC_F, 32'h3104);

    imem_ready = 1'b0;
    redir(2'b10, 32'h0, 32'h0, 32'h3200);
    step();
    check("pend1_v", {31'b0, pend_valid}, 32'd1);
    check("pend1_pc", PC_F, 32'h3104);
    NPC_JR = 32'h3300;
    step();
    check("pend2_v", {31'b0, pend_valid}, 32'd1);
    check("pend2_pc", PC_F, 32'h3104);
    redirect_valid = 1'b0; imem_ready = 1'b1;
    step();
    check("pend_apply_pc", PC_F, 32'h3300);
    check("pend_apply_cnt", {16'b0, redirect_cnt}, 32'd2);
    check("pend_clr", {31'b0, pend_valid}, 32'd0);
    check("sat_cnt2", {30'b0, cnt_s}, 32'd2);

    stall_D = 1'b1;
    redir(2'b01, 32'h0, 32'h4000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", PC_F, 32'h3300);
      check("stall_pend", {31'b0, pend_valid}, 32'd0);
      check("stall_cnt", {16'b0, redirect_cnt}, 32'd2);
    end
    stall_D = 1'b0; redirect_valid = 1'b0;
    step(); check("seq_3304", PC_F, 32'h3304);

    redir(2'b10, 32'h0, 32'h0, 32'h3202);
    step();
    check("mis_pc", PC_F, 32'h3200);
    check("mis_err", {31'b0, addr_err}, 32'd1);
    check("sat_cnt3", {30'b0, cnt_s}, 32'd3);
    redirect_valid = 1'b0;
    step();
    check("seq_3204", PC_F, 32'h3204);
    check("err_hold", {31'b0, addr_err}, 32'd1);

    redir(2'b11, 32'h5000, 32'h6000, 32'h7000);
    step();
    check("rsvd_pc", PC_F, 32'h5000);
    check("rsvd_cnt", {16'b0, redirect_cnt}, 32'd4);
    check("sat_hold", {30'b0, cnt_s}, 32'd3);

    redir(2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0);
    step(); check("pre_wrap", PC_F, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check("wrap_pc", PC_F, 32'h0000_0000);
    check("wrap_cnt", {16'b0, redirect_cnt}, 32'd5);
    check("wrap_err", {31'b0, addr_err}, 32'd1);

    imem_ready = 1'b0;
    redir(2'b10, 32'h0, 32'h0, 32'h7000);
    step();
    check("rst_pend_set", {31'b0, pend_valid}, 32'd1);
    redirect_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_pc", PC_F, 32'h3000);
    check("arst_pend", {31'b0, pend_valid}, 32'd0);
    check("arst_freq", {31'b0, fetch_req}, 32'd0);
    check("arst_err", {31'b0, addr_err}, 32'd0);
    check("arst_cnt", {16'b0, redirect_cnt}, 32'd0);
    step();
    reset = 1'b1; imem_ready = 1'b1;
    redir(2'b01, 32'h0, 32'h8000, 32'h0);
    step();
    check("boot_ign_pc", PC_F, 32'h3000);
    check("boot_ign_pend", {31'b0, pend_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    check("post_rst_pc", PC_F, 32'h3004);
    check("post_rst_cnt", {16'b0, redirect_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
